// File: rtl/edge_triggered_tff.sv
// Toggle flip-flop: q inverts on each rising clk edge while t is high.
// reset is asynchronous and clears q without waiting for an edge.
`timescale 1ns/1ps
module edge_triggered_tff (
  input  logic t,
  input  logic reset,
  input  logic clk,
  output logic q
);

  // XOR feedback propagates an unknown t into q rather than masking it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: tb/tb_edge_triggered_tff.sv
// Directed and randomized checks of edge_triggered_tff against a parity model.
`timescale 1ns/1ps
module tb_edge_triggered_tff;

  logic t;
  logic reset;
  logic clk;
  logic q;

  int tests_run = 0;
  int tests_failed = 0;
  int model_q = 0;   // number of applied toggles since reset, modulo 2
  time t_mark;

  edge_triggered_tff dut (
    .t    (t),
    .reset(reset),
    .clk  (clk),
    .q    (q)
  );

  task automatic check(input string tag, input logic expected);
    tests_run++;
    assert (q === expected) else begin
      tests_failed++;
      $error("FAIL %s: q=%b expected=%b at %0t", tag, q, expected, $time);
    end
    $display("[TB] %s q=%b expected=%b", tag, q, expected);
  endtask

  // Rising edge: the model applies the toggle rule using the level of t at the edge.
  task automatic rise();
    clk = 1'b1;
    if (reset) model_q = 0;
    else model_q = (model_q + int'(t)) % 2;
    #1;
  endtask

  task automatic fall();
    clk = 1'b0;
    #1;
  endtask

  initial begin
    clk = 1'b0;
    t = 1'b0;
    reset = 1'b0;
    #5;

    // Reset held with t=1 and clock running: q stays 0 throughout.
    reset = 1'b1;
    t = 1'b1;
    model_q = 0;
    #1;
    check("reset_async_assert", 1'b0);
    for (int i = 0; i < 3; i++) begin
      rise();
      check("reset_after_rise", 1'b0);
      #3;
      check("reset_mid_high", 1'b0);
      fall();
      check("reset_after_fall", 1'b0);
      #3;
    end
    reset = 1'b0;
    #2;
    check("reset_released", 1'b0);

    // Toggle: 1,0,1,0 after successive edges.
    t = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rise();
      check("toggle_seq", (i % 2 == 0) ? 1'b1 : 1'b0);
      #3;
      fall();
      #3;
    end

    // Reach q=1, then hold with t=0.
    rise(); check("toggle_to_one", 1'b1); #3; fall(); #3;
    t = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rise(); check("hold_t0", 1'b1); #3; fall(); #3;
    end
    // Glitch on t while clk is low must not be sampled.
    t = 1'b1; #1; check("glitch_no_edge", 1'b1); t = 1'b0; #1;
    rise(); check("glitch_ignored", 1'b1); #3;
    // Glitch on t during the high phase is ignored too.
    t = 1'b1; #1; t = 1'b0; #1;
    check("glitch_high_phase", 1'b1);
    fall(); #3;

    // Async reset mid-run with clk low: q clears in the same time step.
    t_mark = $time;
    reset = 1'b1;
    model_q = 0;
    fork
      begin : wait_clear
        if (q !== 1'b0) @(q);
      end
      begin : wait_timeout
        #1;
      end
    join_any
    disable fork;
    tests_run++;
    assert ($time == t_mark) else begin
      tests_failed++;
      $error("FAIL async_reset_same_step: cleared_at=%0t required=%0t", $time, t_mark);
    end
    check("async_reset_clear", 1'b0);
    #2;
    reset = 1'b0;
    t = 1'b1;
    #2;
    rise(); check("after_async_reset", 1'b1); #3; fall(); #3;
    rise(); check("back_to_zero", 1'b0); #3; fall(); #3;

    // Collision: reset and clk rise in the same time step with t=1, q=0.
    t = 1'b1;
    reset = 1'b1;
    rise();
    check("collision_reset_wins", 1'b0);
    #2;
    reset = 1'b0;   // released while clk is high, so no edge follows
    #1;
    check("release_in_high", 1'b0);
    // Falling edge only, with t=1: q holds.
    fall();
    check("falling_edge_only", 1'b0);
    #3;

    // Randomized run: t sampled per edge, t glitches between edges,
    // occasional asynchronous reset pulses during the low phase.
    for (int i = 0; i < 300; i++) begin
      t = 1'($urandom_range(0, 1));
      #1;
      rise();
      check("rand_after_rise", model_q[0]);
      t = 1'($urandom_range(0, 1));
      #2;
      check("rand_mid_high", model_q[0]);
      fall();
      check("rand_after_fall", model_q[0]);
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        model_q = 0;
        #1;
        check("rand_async_reset", 1'b0);
        reset = 1'b0;
      end
      t = 1'($urandom_range(0, 1));
      #2;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/edge_triggered_tff.md
EDGE_TRIGGERED_TFF -- requirements
Module: edge_triggered_tff

Interface
REQ-001 Parameters: none; the block SHALL NOT be parameterised.
REQ-002 Ports SHALL be declared in this positional order: t, reset, clk, q, so the block is instantiable by position.
REQ-003 clk  input  1  single clock; all state changes except reset SHALL occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; forces q to 0 independent of clk.
REQ-005 t  input  1  toggle enable; sampled on clk rising edge.
REQ-006 q  output  1  flip-flop state, driven directly from the storage element with no combinational path from t.

Function
REQ-007 On a clk rising edge with reset=0 and t=1, q SHALL invert (0->1 or 1->0).
REQ-008 On a clk rising edge with reset=0 and t=0, q SHALL hold its value.
REQ-009 Latency: the new q value SHALL be visible after the triggering clk rising edge, within the same clk high phase; no additional pipeline delay.
REQ-010 q SHALL NOT change on a clk falling edge, nor on t changes while clk is stable.
REQ-011 t SHALL be treated as a level sampled only at the rising edge; glitches on t between edges SHALL have no effect.
REQ-012 Successive rising edges with t held at 1 SHALL produce q toggling every edge (divide-by-two of clk).
REQ-013 If t is X or Z at a rising edge with reset=0, q SHALL become X (no silent masking).

Reset
REQ-014 reset=1 SHALL force q to 0 immediately, without waiting for a clk edge.
REQ-015 While reset=1, q SHALL stay 0 regardless of clk edges or t.
REQ-016 Simultaneous reset assertion and clk rising edge: reset SHALL win; q=0.
REQ-017 After reset deasserts, the first clk rising edge SHALL apply REQ-007/REQ-008 starting from q=0.
REQ-018 Before the first reset assertion q is unspecified (X permitted); users SHALL reset the block before relying on q.
REQ-019 Reset asserted mid-operation (q=1, toggling) SHALL clear q to 0 asynchronously; no toggle history is retained.

Structure
REQ-020 No shared package is required; the block defines no typedefs or constants.
REQ-021 Implementation SHALL be a single always block sensitive to posedge clk and posedge reset, with next state = q XOR t.
REQ-022 An optional sub-module dff_async_reset (D, reset, clk, Q) with an XOR feedback SHALL be the only permitted decomposition; behaviour SHALL be identical either way.
REQ-023 The design SHALL be fully synthesisable, with no latches and no initial blocks in the RTL.

Verification
REQ-024 Reset: reset=1, t=1, clk toggling for 3 cycles -> q=0 throughout, including between edges.
REQ-025 Toggle: reset=0, q=0, t=1, 4 rising edges -> q sequence 1,0,1,0 sampled after each edge.
REQ-026 Hold: q=1, t=0, 3 rising edges -> q stays 1; t pulsed 1 while clk low then back to 0 before the edge -> q stays 1.
REQ-027 Async reset mid-run: q=1, assert reset while clk=0 with no edge -> q=0 within the same time step; deassert, t=1, one rising edge -> q=1.
REQ-028 Collision: reset rises at the same time step as a clk rising edge with t=1 and q=0 -> q=0.
REQ-029 Falling-edge check: q=0, t=1, apply a clk falling edge only -> q remains 0.
